// File: rtl/iir_deemph_if.sv
// FIFO-side signals of the de-emphasis filter: input FIFO pop side and output FIFO push side.
interface iir_deemph_if #(parameter int DATA_SIZE = 32);
    logic                 in_empty;
    logic                 in_rd_en;
    logic [DATA_SIZE-1:0] din;
    logic                 out_full;
    logic                 out_wr_en;
    logic [DATA_SIZE-1:0] dout;

    modport master (input in_empty, din, out_full, output in_rd_en, out_wr_en, dout);
    modport slave  (output in_empty, din, out_full, input in_rd_en, out_wr_en, dout);
endinterface

// File: rtl/iir_deemph.sv
// First-order IIR de-emphasis: y[n] = DEQ(X0*x[n] + X1*x[n-1]) + DEQ(Y1*y[n-1]), READ/MULT/WRITE FSM.
// Define IIR_DEEMPH_SATURATE_EN to clamp the 2*DATA_SIZE sum instead of wrapping it.
module iir_deemph #(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10,
    parameter int X0        = 178,
    parameter int X1        = 178,
    parameter int Y1        = -666
) (
    input logic          clock,
    input logic          reset,
    iir_deemph_if.master bus
);
    localparam int W = 2 * DATA_SIZE;

    localparam logic [1:0] S_READ  = 2'd0;
    localparam logic [1:0] S_MULT  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic signed [W-1:0] C_X0 = W'(X0);
    localparam logic signed [W-1:0] C_X1 = W'(X1);
    localparam logic signed [W-1:0] C_Y1 = W'(Y1);
    localparam logic signed [W-1:0] BIAS = {{(W-BITS){1'b0}}, {BITS{1'b1}}};
    localparam logic signed [W-1:0] SMAX = {{(W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = ~SMAX;

    logic [1:0]                  state_q, state_d;
    logic                        run_q;
    logic signed [DATA_SIZE-1:0] x_cur_q, x_cur_d, x_prev_q, x_prev_d, y_prev_q, y_prev_d;
    logic signed [W-1:0]         p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic signed [W-1:0]         sum;
    logic signed [DATA_SIZE-1:0] y_out;
    logic                        rd_en, wr_en;

    // Truncate toward zero: negative values are biased up before the arithmetic shift.
    function automatic logic signed [W-1:0] deq(input logic signed [W-1:0] v);
        logic signed [W-1:0] t;
        t = v + (v[W-1] ? BIAS : '0);
        return t >>> BITS;
    endfunction

    always_comb begin
        sum = deq(p0_q + p1_q) + deq(p2_q);
`ifdef IIR_DEEMPH_SATURATE_EN
        if (sum > SMAX)      y_out = SMAX[DATA_SIZE-1:0];
        else if (sum < SMIN) y_out = SMIN[DATA_SIZE-1:0];
        else                 y_out = sum[DATA_SIZE-1:0];
`else
        y_out = sum[DATA_SIZE-1:0];
`endif
    end

    always_comb begin
        state_d  = state_q;
        x_cur_d  = x_cur_q;
        x_prev_d = x_prev_q;
        y_prev_d = y_prev_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            // run_q keeps the release cycle from popping
            S_READ: if (run_q && !bus.in_empty) begin
                rd_en   = 1'b1;
                x_cur_d = bus.din;
                state_d = S_MULT;
            end
            S_MULT: begin
                p0_d    = C_X0 * W'(x_cur_q);
                p1_d    = C_X1 * W'(x_prev_q);
                p2_d    = C_Y1 * W'(y_prev_q);
                state_d = S_WRITE;
            end
            S_WRITE: if (!bus.out_full) begin
                wr_en    = 1'b1;
                x_prev_d = x_cur_q;
                y_prev_d = y_out;
                state_d  = S_READ;
            end
            default: state_d = S_READ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_READ;
            run_q    <= 1'b0;
            x_cur_q  <= '0;
            x_prev_q <= '0;
            y_prev_q <= '0;
            p0_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            x_cur_q  <= x_cur_d;
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
        end
    end

    assign bus.in_rd_en  = rd_en;
    assign bus.out_wr_en = wr_en;
    assign bus.dout      = y_out;
endmodule

// File: tb/tb_iir_deemph.sv
// Bench for iir_deemph: directed impulse/step/stall/reset cases plus randomized streams vs. a reference model.
module tb_iir_deemph;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    longint last_y;

    always #5 clock = ~clock;

    iir_deemph_if #(.DATA_SIZE(32)) u ();
    iir_deemph_if #(.DATA_SIZE(32)) ov ();

    iir_deemph dut (.clock(clock), .reset(reset), .bus(u));
    iir_deemph #(.X0(1024), .X1(1024), .Y1(0)) dut_ov (.clock(clock), .reset(reset), .bus(ov));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint narrow(input longint s);
`ifdef IIR_DEEMPH_SATURATE_EN
        if (s > 64'sd2147483647) return 64'sd2147483647;
        if (s < -64'sd2147483648) return -64'sd2147483648;
        return s;
`else
        return longint'(int'(s));
`endif
    endfunction

    // Reference filter on plain integers; SV '/' already truncates toward zero.
    function automatic void model(input longint xs[$], output longint ys[$]);
        longint xp = 0, yp = 0, y;
        ys = {};
        foreach (xs[i]) begin
            y = narrow((178 * xs[i] + 178 * xp) / 1024 + (-666 * yp) / 1024);
            ys.push_back(y);
            xp = xs[i];
            yp = y;
        end
    endfunction

    task automatic run_seq(input string tag, input longint xs[$], input longint exp[$],
                           input int idle_max, input int full_pct);
        int pi = 0, oi = 0, cyc = 0, gap = 0;
        while (oi < exp.size() && cyc < 3000) begin
            @(negedge clock);
            u.in_empty = (pi >= xs.size()) || (gap > 0);
            u.din      = (pi < xs.size()) ? 32'(xs[pi]) : '0;
            u.out_full = ($urandom_range(0, 99) < full_pct);
            #1;
            if (u.in_empty) chk({tag, "_rd_when_empty"}, longint'(u.in_rd_en), 0);
            if (u.out_full) chk({tag, "_wr_when_full"}, longint'(u.out_wr_en), 0);
            if (u.in_rd_en) begin
                chk({tag, "_pop_with_pending"}, pi, oi);
                pi++;
                gap = $urandom_range(0, idle_max);
            end else if (u.in_empty && gap > 0) begin
                gap--;
            end
            if (u.out_wr_en) begin
                last_y = longint'($signed(u.dout));
                chk($sformatf("%s_y%0d", tag, oi), last_y, exp[oi]);
                oi++;
            end
            cyc++;
        end
        if (oi < exp.size()) chk({tag, "_timeout_outputs"}, oi, exp.size());
        @(negedge clock);
        u.in_empty = 1'b1;
        u.out_full = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        u.in_empty = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        longint xs[$], ys[$];
        int done;
        u.in_empty = 1'b1; u.din = '0; u.out_full = 1'b0;
        ov.in_empty = 1'b1; ov.din = '0; ov.out_full = 1'b0;

        // Reset state, with a sample already waiting at release
        repeat (2) @(negedge clock);
        u.in_empty = 1'b0; u.din = 32'd1024;
        #1;
        chk("rst_rd_en", longint'(u.in_rd_en), 0);
        chk("rst_wr_en", longint'(u.out_wr_en), 0);
        chk("rst_dout", longint'($signed(u.dout)), 0);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("release_no_pop", longint'(u.in_rd_en), 0);

        run_seq("impulse", '{1024, 0, 0}, '{178, 63, -40}, 0, 0);

        // DC step
        xs = {};
        repeat (20) xs.push_back(1024);
        model(xs, ys);
        do_reset();
        run_seq("dc_head", xs[0:4], '{178, 241, 200, 226, 210}, 0, 0);
        do_reset();
        run_seq("dc", xs, ys, 0, 0);
        chk("dc_settle", longint'((last_y >= 214) && (last_y <= 218)), 1);

        // Random samples with idle gaps and random backpressure
        do_reset();
        xs = {};
        for (int i = 0; i < 40; i++)
            xs.push_back((i % 8 == 7) ? longint'($signed($urandom)) : longint'($signed($urandom) >>> 9));
        model(xs, ys);
        run_seq("rand_sparse", xs, ys, 5, 30);
        do_reset();
        run_seq("rand_b2b", xs, ys, 0, 0);

        // Reset while in MULT discards the sample and clears history
        @(negedge clock);
        u.in_empty = 1'b0; u.din = 32'd1024;
        #1 chk("rm_pop", longint'(u.in_rd_en), 1);
        @(negedge clock);
        u.in_empty = 1'b1;
        reset = 1'b0;
        #1;
        chk("rm_dout", longint'($signed(u.dout)), 0);
        chk("rm_wr_en", longint'(u.out_wr_en), 0);
        chk("rm_rd_en", longint'(u.in_rd_en), 0);
        @(negedge clock);
        reset = 1'b1;
        run_seq("rm_impulse", '{1024, 0, 0}, '{178, 63, -40}, 0, 0);

        // Held backpressure in WRITE with the next sample already available
        do_reset();
        @(negedge clock);
        u.in_empty = 1'b0; u.din = 32'd1024; u.out_full = 1'b1;
        #1 chk("bp_pop", longint'(u.in_rd_en), 1);
        @(negedge clock);
        u.din = 32'd0;
        #1 chk("bp_mult_rd", longint'(u.in_rd_en), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            chk($sformatf("bp_wr_%0d", i), longint'(u.out_wr_en), 0);
            chk($sformatf("bp_rd_%0d", i), longint'(u.in_rd_en), 0);
            chk($sformatf("bp_dout_%0d", i), longint'($signed(u.dout)), 178);
        end
        @(negedge clock);
        u.out_full = 1'b0;
        #1;
        chk("bp_release_wr", longint'(u.out_wr_en), 1);
        chk("bp_release_dout", longint'($signed(u.dout)), 178);
        chk("bp_release_rd", longint'(u.in_rd_en), 0);
        run_seq("bp_tail", '{0, 0}, '{63, -40}, 0, 0);

        // Overflow on the unity-gain instance
        done = 0;
        for (int c = 0; c < 40 && done < 2; c++) begin
            @(negedge clock);
            ov.in_empty = 1'b0;
            ov.din = 32'h7FFF_FFFF;
            #1;
            if (ov.out_wr_en) begin
`ifdef IIR_DEEMPH_SATURATE_EN
                chk($sformatf("ovf_y%0d", done), longint'(ov.dout), 64'h7FFF_FFFF);
`else
                chk($sformatf("ovf_y%0d", done), longint'(ov.dout), (done == 0) ? 64'h7FFF_FFFF : 64'hFFFF_FFFE);
`endif
                done++;
            end
        end
        ov.in_empty = 1'b1;
        if (done < 2) chk("ovf_timeout", done, 2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/iir_deemph.md
# iir_deemph

First-order fixed-point IIR de-emphasis filter in the FM receiver audio path, directly upstream of the gain stage. It pops one demodulated audio sample from its input FIFO and computes `y[n] = DEQ(X0·x[n] + X1·x[n-1]) + DEQ(Y1·y[n-1])`. It pushes `y[n]` into the FIFO that feeds gain. Filter history is kept internally across samples.

## Interface
- `DATA_SIZE`, 32, sample and coefficient width (signed two's complement)
- `BITS`, 10, fractional bits of the quantized coefficients
- `X0`, 178, feed-forward coefficient on `x[n]` (signed, Q`BITS`)
- `X1`, 178, feed-forward coefficient on `x[n-1]`
- `Y1`, -666, feedback coefficient on `y[n-1]`
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset; the block is held in reset while `reset`=0
- `in_empty`  in  1  input FIFO empty flag
- `in_rd_en`  out  1  input FIFO pop strobe
- `din`  in  DATA_SIZE  input sample; first-word-fall-through, valid while `in_empty`=0
- `out_full`  in  1  output FIFO full flag
- `out_wr_en`  out  1  output FIFO push strobe
- `dout`  out  DATA_SIZE  filtered sample, signed

## Operation
- `DEQ(v)` is `v / 2**BITS`, a signed division truncating toward zero. It is not an arithmetic shift: `DEQ(-1)`=0.
- Products and sums are computed at 2·DATA_SIZE bits. The two `DEQ` results are added at 2·DATA_SIZE bits and then narrowed to DATA_SIZE.
- `y[n-1]` is stored as the narrowed value, i.e. exactly what appeared on `dout`.
- The state machine has three states:
  - **READ**: if `in_empty`=0, assert `in_rd_en` for this cycle (combinational), capture `din` into `x_cur`, and go to MULT. Otherwise stay in READ.
  - **MULT**: register the products `X0·x_cur`, `X1·x_prev` and `Y1·y_prev`, then go to WRITE.
  - **WRITE**: the output value is formed from the MULT registers and held on `dout`.
    - If `out_full`=0: assert `out_wr_en`, set `x_prev`←`x_cur` and `y_prev`←output, then go to READ.
    - Otherwise stay in WRITE with `out_wr_en`=0 and `dout` stable.
- `in_rd_en` is asserted only in READ. `out_wr_en` is asserted only in WRITE.
- No sample is dropped or duplicated under any pattern of `in_empty` or `out_full`.
- History (`x_prev`, `y_prev`) is zero after reset. The first output is therefore `DEQ(X0·x[0])`.

## Timing
- Reset values: `in_rd_en`=0, `out_wr_en`=0, `dout`=0, state READ, all history and pipeline registers 0.
- Reset asserted mid-operation takes effect immediately: any in-flight sample is discarded and history is cleared.
- Latency: pop in cycle t (READ), products registered at end of t+1 (MULT), `out_wr_en`=1 in t+2 if `out_full`=0.
- Throughput: one sample per 3 cycles at best.
- `in_empty` and `out_full` are sampled in the same cycle as the strobe they gate.
- The block never pops while it holds an unwritten result.
- A `reset` deassertion edge coinciding with `in_empty`=0 produces no pop in that cycle; the first pop is in the following cycle.

## Configuration
- `IIR_DEEMPH_SATURATE_EN`
  - Defined: the 2·DATA_SIZE sum is clamped to [−2^(DATA_SIZE−1), 2^(DATA_SIZE−1)−1] before narrowing.
  - Undefined: the low DATA_SIZE bits are kept (two's-complement wrap).
- The stored `y[n-1]` follows the same rule in both cases.

## Test plan
- Impulse, defaults: `din` = 1024, 0, 0 -> `dout` = 178, 63, -40.
- DC step, defaults: constant 1024 -> 178, 241, 200, 226, 210, …; settles within ±2 of 216 by sample 20.
- Backpressure: hold `out_full`=1 for 10 cycles while in WRITE -> `out_wr_en`=0, `dout` stable, `in_rd_en`=0. After release, one push occurs and the sequence is identical to the unstalled run.
- Sparse input: insert 0–5 idle cycles of `in_empty`=1 between samples -> output sequence identical to the back-to-back run; `in_rd_en` is never high while `in_empty`=1.
- Reset in MULT: pulse `reset`=0 mid-impulse -> all outputs 0 immediately. A following impulse of 1024 yields 178, 63, -40.
- Overflow: `X0`=`X1`=1024, `Y1`=0, `din` = 0x7FFFFFFF twice -> second output 0x7FFFFFFF with `IIR_DEEMPH_SATURATE_EN` defined, 0xFFFFFFFE without it.
